// File: rtl/psram_line_fetch.sv
// Scanline prefetcher: pulls one line of 16-bit words from the PSRAM controller
// into the back bank of a ping-pong buffer while the video side reads the front bank.
module psram_line_fetch #(
    parameter int LINE_WORDS = 320,
    parameter int ADDR_STEP  = 1,
    parameter int IDX_W      = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_line_start,
    input  logic [23:0]      i_line_base,
    input  logic             i_swap,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [15:0]      o_rd_data,
    output logic             o_fetch_busy,
    output logic             o_overrun,
    output logic             o_mem_stb,
    output logic             o_mem_we,
    output logic [23:0]      o_mem_addr,
    input  logic             i_mem_busy,
    input  logic             i_mem_done,
    input  logic [15:0]      i_mem_dout,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_READY  = 2'd1;
    localparam logic [1:0] ST_WAIT_ACCEPT = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE   = 2'd3;

    localparam int             AW       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(LINE_WORDS - 1);
    localparam logic [IDX_W:0] DEPTH    = (IDX_W + 1)'(LINE_WORDS);
    localparam logic [23:0]    STEP     = 24'(ADDR_STEP);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [23:0]      addr_q, addr_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             front_q, front_d;
    logic             pend_q, pend_d;
    logic [15:0]      rd_data_q, rd_data_d;

    logic             mem_idle;
    logic             wr_en;
    logic             last_wr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx_s;
    logic             rd_ok;
    logic [15:0]      rd_word;

    logic [15:0] bank0_q [LINE_WORDS];
    logic [15:0] bank1_q [LINE_WORDS];

    // Controller is free only with done high and busy low; done alone is sticky.
    assign mem_idle = i_mem_done & ~i_mem_busy;
    assign wr_idx   = cnt_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        stb_d   = stb_q;
        busy_d  = busy_q;
        front_d = front_q;
        pend_d  = pend_q;
        wr_en   = 1'b0;
        last_wr = 1'b0;
        ovr_d   = i_line_start & busy_q;

        case (state_q)
            ST_IDLE: begin
                if (i_line_start) begin
                    addr_d  = i_line_base;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (mem_idle) begin
                    stb_d   = 1'b1;
                    state_d = ST_WAIT_ACCEPT;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (i_mem_busy || !i_mem_done) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (mem_idle) begin
                    wr_en = 1'b1;
                    if ({1'b0, cnt_q} == LAST_IDX) begin
                        last_wr = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = addr_q + STEP;
                        state_d = ST_WAIT_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A swap requested during a fetch is held until the last word lands,
        // so the video side never sees a partially written line.
        if (last_wr) begin
            front_d = front_q ^ (pend_q | i_swap);
            pend_d  = 1'b0;
        end else if (i_swap) begin
            if (busy_q) begin
                pend_d = 1'b1;
            end else begin
                front_d = ~front_q;
            end
        end
    end

    assign rd_idx_s  = i_rd_idx[AW-1:0];
    assign rd_ok     = ({1'b0, i_rd_idx} < DEPTH);
    assign rd_word   = front_q ? bank1_q[rd_idx_s] : bank0_q[rd_idx_s];
    assign rd_data_d = rd_ok ? rd_word : 16'h0000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= 24'h000000;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            front_q   <= front_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Line storage is not reset; only the back bank is ever written.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            if (front_q) begin
                bank0_q[wr_idx] <= i_mem_dout;
            end else begin
                bank1_q[wr_idx] <= i_mem_dout;
            end
        end
    end

    assign o_rd_data    = rd_data_q;
    assign o_fetch_busy = busy_q;
    assign o_overrun    = ovr_q;
    assign o_mem_stb    = stb_q;
    assign o_mem_we     = 1'b0;
    assign o_mem_addr   = addr_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_psram_line_fetch.sv
// Bench for psram_line_fetch: behavioural PSRAM controller, line/bank reference
// model, vector tables, hand-written corner sequences and randomized lines.
module tb_psram_line_fetch;

    localparam int LW = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_line_start;
    logic [23:0]   i_line_base;
    logic          i_swap;
    logic [IW-1:0] i_rd_idx;
    logic [15:0]   o_rd_data;
    logic          o_fetch_busy;
    logic          o_overrun;
    logic          o_mem_stb;
    logic          o_mem_we;
    logic [23:0]   o_mem_addr;
    logic          mem_busy;
    logic          mem_done;
    logic [15:0]   mem_dout;
    logic [1:0]    o_dbg_state;

    always #5 clk = ~clk;

    psram_line_fetch #(.LINE_WORDS(LW), .ADDR_STEP(1), .IDX_W(IW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_line_start (i_line_start),
        .i_line_base  (i_line_base),
        .i_swap       (i_swap),
        .i_rd_idx     (i_rd_idx),
        .o_rd_data    (o_rd_data),
        .o_fetch_busy (o_fetch_busy),
        .o_overrun    (o_overrun),
        .o_mem_stb    (o_mem_stb),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .i_mem_busy   (mem_busy),
        .i_mem_done   (mem_done),
        .i_mem_dout   (mem_dout),
        .o_dbg_state  (o_dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural PSRAM controller, acting on the falling edge.
    int          init_cnt = 50;
    int          lat = 3;
    int          rem = 0;
    logic [23:0] cur_addr = 24'h0;
    logic [23:0] stb_log[$];

    initial begin
        mem_busy = 1'b1;
        mem_done = 1'b0;
        mem_dout = 16'h0000;
    end

    always @(negedge clk) begin
        logic        r;
        logic        s;
        logic [23:0] a;
        r = rst_n;
        s = o_mem_stb;
        a = o_mem_addr;
        if (init_cnt > 0) begin
            if (r) begin
                init_cnt--;
                if (init_cnt == 0) begin
                    mem_busy = 1'b0;
                    mem_done = 1'b1;
                end
            end
        end else if (!r) begin
            mem_busy = 1'b0;
            mem_done = 1'b1;
        end else if (mem_done && !mem_busy) begin
            if (s) begin
                stb_log.push_back(a);
                cur_addr = a;
                mem_busy = 1'b1;
                mem_done = 1'b0;
                rem      = lat;
            end
        end else begin
            check("addr_stable", a, cur_addr);
            check("stb_low_busy", s, 0);
            if (rem <= 1) begin
                mem_busy = 1'b0;
                mem_done = 1'b1;
                mem_dout = cur_addr[15:0];
            end else begin
                rem--;
            end
        end
    end

    // Reference model: two banks, which one is in front, which hold known data.
    logic [15:0] mbank[2][LW];
    bit          mvalid[2];
    int          mfront = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_line(input logic [23:0] base);
        logic [23:0] a;
        for (int i = 0; i < LW; i++) begin
            a = base + 24'(i);
            mbank[mfront ^ 1][i] = a[15:0];
        end
        mvalid[mfront ^ 1] = 1'b1;
    endtask

    task automatic check_strobes(input logic [23:0] base);
        logic [23:0] e;
        check("stb_count", stb_log.size(), LW);
        for (int i = 0; i < stb_log.size() && i < LW; i++) begin
            e = base + 24'(i);
            check("stb_addr", stb_log[i], e);
        end
    endtask

    task automatic idle_swap();
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        mfront ^= 1;
    endtask

    task automatic read_idx(input int idx);
        logic [15:0] e;
        i_rd_idx = IW'(idx);
        tick();
        e = (idx < LW) ? mbank[mfront][idx] : 16'h0000;
        if (idx >= LW || mvalid[mfront]) check("rd_model", o_rd_data, e);
    endtask

    // One full line; swap_at/ovr_at = strobe count at which to pulse swap / a stray start.
    task automatic fetch_line(input logic [23:0] base, input int l, input int swap_at, input int ovr_at);
        int          k;
        int          ov_state = 0;
        bit          sw_done = 0;
        bit          known;
        logic [15:0] old0;
        known        = mvalid[mfront];
        old0         = mbank[mfront][0];
        lat          = l;
        stb_log.delete();
        i_rd_idx     = '0;
        i_line_base  = base;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        check("busy_rise", o_fetch_busy, 1);
        for (k = 0; k < 3000; k++) begin
            if (!o_fetch_busy) break;
            if (known) check("front_hold", o_rd_data, old0);
            if (ov_state == 1) begin
                check("overrun_pulse", o_overrun, 1);
                ov_state = 2;
            end else if (ov_state == 2) begin
                check("overrun_clear", o_overrun, 0);
                ov_state = 3;
            end
            i_swap       = 1'b0;
            i_line_start = 1'b0;
            if (swap_at > 0 && !sw_done && stb_log.size() >= swap_at) begin
                i_swap  = 1'b1;
                sw_done = 1'b1;
            end
            if (ovr_at > 0 && ov_state == 0 && stb_log.size() >= ovr_at) begin
                i_line_start = 1'b1;
                i_line_base  = ~base;
                ov_state     = 1;
            end
            tick();
        end
        i_swap       = 1'b0;
        i_line_start = 1'b0;
        if (k == 3000) check("fetch_timeout", 0, 1);
        if (known) check("front_hold_last", o_rd_data, old0);
        model_line(base);
        if (sw_done) mfront ^= 1;
        tick();
        if (mvalid[mfront]) check("front_after", o_rd_data, mbank[mfront][0]);
        check_strobes(base);
    endtask

    typedef struct {
        logic [23:0] base;
        int          lat;
        logic [23:0] exp_last;
    } line_vec_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [15:0]   exp;
    } rd_vec_t;

    line_vec_t line_tab[3];
    rd_vec_t   rd_tab[6];

    initial begin
        int k;
        line_tab[0] = '{24'h001000, 3,  24'h001003};
        line_tab[1] = '{24'hFFFFFE, 2,  24'h000001};
        line_tab[2] = '{24'h7FFFFF, 20, 24'h800002};
        rd_tab[0] = '{3'd2, 16'h1002};
        rd_tab[1] = '{3'd0, 16'h1000};
        rd_tab[2] = '{3'd3, 16'h1003};
        rd_tab[3] = '{3'd1, 16'h1001};
        rd_tab[4] = '{3'd4, 16'h0000};
        rd_tab[5] = '{3'd7, 16'h0000};

        rst_n        = 1'b0;
        i_line_start = 1'b0;
        i_line_base  = 24'h0;
        i_swap       = 1'b0;
        i_rd_idx     = '0;
        repeat (3) tick();
        check("rst_stb", o_mem_stb, 0);
        check("rst_busy", o_fetch_busy, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_state", o_dbg_state, 0);
        check("mem_we", o_mem_we, 0);
        rst_n = 1'b1;
        tick();

        // Table lines: first one also waits out the controller init.
        for (int t = 0; t < 3; t++) begin
            fetch_line(line_tab[t].base, line_tab[t].lat, 0, 0);
            if (stb_log.size() >= LW) check("last_addr", stb_log[LW-1], line_tab[t].exp_last);
            check("idle_after_line", o_dbg_state, 0);
            idle_swap();
            if (t == 0) begin
                for (int v = 0; v < 6; v++) begin
                    i_rd_idx = rd_tab[v].idx;
                    tick();
                    check("rd_table", o_rd_data, rd_tab[v].exp);
                end
            end else begin
                for (int i = 0; i < 8; i++) read_idx(i);
            end
        end

        // Stray start mid-fetch, then a deferred swap (two pulses collapse to one flip).
        fetch_line(24'h002000, 5, 0, 2);
        fetch_line(24'h003000, 4, 2, 0);
        fetch_line(24'h003800, 2, 1, 0);
        for (int i = 0; i < 5; i++) read_idx(i);

        lat = 3;
        stb_log.delete();
        i_line_base  = 24'h004000;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        i_swap       = 1'b1;
        tick();
        i_swap       = 1'b0;
        tick();
        i_swap       = 1'b1;
        tick();
        i_swap       = 1'b0;
        // Start arriving in the same cycle as the final word write.
        for (k = 0; k < 3000; k++) begin
            if (stb_log.size() == LW && mem_done && !mem_busy) break;
            tick();
        end
        if (k == 3000) check("late_timeout", 0, 1);
        i_line_base  = 24'h005000;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        check("late_overrun", o_overrun, 1);
        check("late_idle", o_fetch_busy, 0);
        tick();
        check("late_overrun_clr", o_overrun, 0);
        repeat (10) tick();
        check_strobes(24'h004000);
        check("late_state", o_dbg_state, 0);
        model_line(24'h004000);
        mfront ^= 1;
        for (int i = 0; i < 4; i++) read_idx(i);

        // Reset while the controller is working on word 1.
        lat = 10;
        stb_log.delete();
        i_line_base  = 24'h006000;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        for (k = 0; k < 3000; k++) begin
            if (stb_log.size() == 2 && mem_busy && !o_mem_stb) break;
            tick();
        end
        if (k == 3000) check("mid_timeout", 0, 1);
        check("mid_state", o_dbg_state, 3);
        rst_n = 1'b0;
        #1;
        check("arst_stb", o_mem_stb, 0);
        check("arst_busy", o_fetch_busy, 0);
        check("arst_overrun", o_overrun, 0);
        check("arst_rd_data", o_rd_data, 0);
        check("arst_addr", o_mem_addr, 0);
        check("arst_state", o_dbg_state, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        mfront    = 0;
        mvalid[0] = 1'b0;
        mvalid[1] = 1'b0;
        tick();
        fetch_line(24'h007000, 3, 0, 0);
        idle_swap();
        for (int i = 0; i < 8; i++) read_idx(i);

        // Randomized lines against the model.
        for (int r = 0; r < 8; r++) begin
            fetch_line(24'($urandom), $urandom_range(1, 8), $urandom_range(0, LW),
                       $urandom_range(0, LW - 1));
            if ($urandom_range(0, 1) == 1) idle_swap();
            for (int j = 0; j < 3; j++) read_idx($urandom_range(0, 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
